ssd_mux: RTL and testbench

Parametrised multi-digit seven-segment display driver, successor to the two-digit driver. It accepts a binary value through a load handshake and converts it to BCD with an internal sequential double-dabble engine. It time-multiplexes `DIGITS` displays through a one-hot select and flags values that do not fit. It sits between the PWM/duty-cycle logic and the board display pins.

---
 rtl/ssd_mux.sv | 165 ++++++++++++++++
 tb/tb_ssd_mux.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ssd_mux.sv
// ssd_mux: multi-digit seven-segment driver with a load handshake, a
// sequential double-dabble binary-to-BCD engine, overflow dash display
// and one-hot time-multiplexed digit scanning.
// Optional feature macro: SSD_LZB_EN (leading-zero blanking).
module ssd_mux #(
  parameter int DIGITS      = 4,
  parameter int BIN_W       = 14,
  parameter int REFRESH_CNT = 20000
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic [BIN_W-1:0]  num_i,
  input  logic              load_i,
  output logic              busy_o,
  output logic              ovf_o,
  output logic [6:0]        a2g_o,
  output logic [DIGITS-1:0] sel_o
);

  localparam int BCD_W  = DIGITS * 4;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int SCAN_W = $clog2(REFRESH_CNT);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  // Segment pattern for one BCD nibble; codes 10..15 show as 0.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b0010111;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1111011;
      4'd7:    return 7'b0001110;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1011111;
      default: return 7'b1111110;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_t;

  state_t             state_reg, state_next;
  logic [BIN_W-1:0]   bin_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [CNT_W-1:0]   bit_cnt_reg;
  logic               ovf_cap_reg;
  logic [BCD_W-1:0]   disp_reg;
  logic               ovf_reg;
  logic [SCAN_W-1:0]  scan_cnt_reg;
  logic [DIGITS-1:0]  sel_reg;
  logic [BCD_W-1:0]   bcd_adj;
  logic [63:0]        num_ext;
  logic [3:0]         nib_sel;
  logic               blank;

  assign num_ext = 64'(num_i);

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                (bcd_reg[4*gi +: 4] + 4'd3) : bcd_reg[4*gi +: 4];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic: load only from IDLE, BIN_W shift steps, then one latch cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load_i) state_next = CONVERT;
      CONVERT: if (bit_cnt_reg == CNT_W'(BIN_W - 1)) state_next = LATCH;
      LATCH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Conversion datapath; the display register only moves in LATCH.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_reg     <= '0;
      bcd_reg     <= '0;
      bit_cnt_reg <= '0;
      ovf_cap_reg <= 1'b0;
      disp_reg    <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (load_i) begin
          bin_reg     <= num_i;
          bcd_reg     <= '0;
          bit_cnt_reg <= '0;
          ovf_cap_reg <= (num_ext >= LIMIT);
        end
        CONVERT: begin
          bcd_reg     <= {bcd_adj[BCD_W-2:0], bin_reg[BIN_W-1]};
          bin_reg     <= {bin_reg[BIN_W-2:0], 1'b0};
          bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
        end
        LATCH: begin
          disp_reg <= bcd_reg;
          ovf_reg  <= ovf_cap_reg;
        end
        default: ;
      endcase
    end
  end

  // Free-running scan: each digit held for REFRESH_CNT cycles, then rotate.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      scan_cnt_reg <= SCAN_W'(REFRESH_CNT - 1);
      sel_reg      <= DIGITS'(1);
    end else if (scan_cnt_reg == '0) begin
      scan_cnt_reg <= SCAN_W'(REFRESH_CNT - 1);
      sel_reg      <= {sel_reg[DIGITS-2:0], sel_reg[DIGITS-1]};
    end else begin
      scan_cnt_reg <= scan_cnt_reg - SCAN_W'(1);
    end
  end

  // Pick the nibble belonging to the currently selected digit.
  always_comb begin
    nib_sel = '0;
    for (int i = 0; i < DIGITS; i++)
      if (sel_reg[i]) nib_sel = nib_sel | disp_reg[4*i +: 4];
  end

`ifdef SSD_LZB_EN
  logic [DIGITS-1:0] upper_zero;
  // A digit is a leading zero when it and every digit above it are zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
    assign upper_zero[gi] = ~|disp_reg[BCD_W-1:4*gi];
  end
  // Digit 0 is never blanked so that a value of 0 still shows "0".
  assign blank = |(sel_reg[DIGITS-1:1] & upper_zero[DIGITS-1:1]);
`else
  assign blank = 1'b0;
`endif

  // Overflow dashes override both blanking and the nibble decode.
  always_comb begin
    a2g_o = seg_decode(nib_sel);
    if (blank)   a2g_o = 7'b0000000;
    if (ovf_reg) a2g_o = 7'b0000001;
  end

  assign busy_o = (state_reg != IDLE);
  assign ovf_o  = ovf_reg;
  assign sel_o  = sel_reg;

endmodule

// File: tb/tb_ssd_mux.sv
// tb_ssd_mux: directed plus random loads checked against an arithmetic
// model of what each digit of the display should show.
module tb_ssd_mux;
  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int RCNT   = 4;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [BIN_W-1:0]  num_i;
  logic              load_i;
  logic              busy_o;
  logic              ovf_o;
  logic [6:0]        a2g_o;
  logic [DIGITS-1:0] sel_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int edges    = 0;
  int shown    = 0;
  int period;
  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0000110, 7'b1101101, 7'b1001111,
                               7'b0010111, 7'b1011011, 7'b1111011, 7'b0001110,
                               7'b1111111, 7'b1011111};

  ssd_mux #(.DIGITS(DIGITS), .BIN_W(BIN_W), .REFRESH_CNT(RCNT)) dut (
    .clk(clk), .rst_ni(rst_ni), .num_i(num_i), .load_i(load_i),
    .busy_o(busy_o), .ovf_o(ovf_o), .a2g_o(a2g_o), .sel_o(sel_o)
  );

  always #5 clk = ~clk;

  // Rising edges since the last reset release; drives the expected scan position.
  always @(posedge clk or negedge rst_ni)
    if (!rst_ni) edges <= 0;
    else         edges <= edges + 1;

  function automatic int pow10(input int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] exp_seg(input int val, input int dig);
    if (val >= pow10(DIGITS)) return 7'b0000001;
`ifdef SSD_LZB_EN
    if (dig > 0 && val < pow10(dig)) return 7'b0000000;
`endif
    return seg_tab[(val / pow10(dig)) % 10];
  endfunction

  function automatic int exp_idx();
    return (edges / RCNT) % DIGITS;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One full frame: scan position and pattern of every selected digit.
  task automatic check_frame();
    repeat (DIGITS * RCNT) begin
      check("sel", 32'(sel_o), 32'(4'b0001 << exp_idx()));
      check("a2g", 32'(a2g_o), 32'(exp_seg(shown, exp_idx())));
      @(negedge clk);
    end
  endtask

  // Load v; optionally poke a second load at busy cycle intr (must be ignored).
  task automatic do_load(input int v, input int intr);
    int n = 0;
    num_i = BIN_W'(v); load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    while (busy_o && n < 40) begin
      check("a2g_hold", 32'(a2g_o), 32'(exp_seg(shown, exp_idx())));
      n++;
      if (n == intr) begin num_i = BIN_W'(1111); load_i = 1'b1; end
      else load_i = 1'b0;
      @(negedge clk);
    end
    load_i = 1'b0;
    check("busy_len", 32'(n), 32'(BIN_W + 1));
    shown = v;
    check("ovf", 32'(ovf_o), 32'(v >= pow10(DIGITS)));
    $display("load %0d: busy %0d cycles, ovf=%0b", v, n, ovf_o);
  endtask

  initial begin
    rst_ni = 1'b0; load_i = 1'b0; num_i = '0;
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(sel_o), 32'd1);
    check("rst_a2g", 32'(a2g_o), 32'b1111110);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    rst_ni = 1'b1;
    check_frame();

    do_load(1234, -1);  check_frame();
    do_load(10000, -1); check_frame();
    do_load(9999, -1);  check_frame();
    do_load(5678, 5);   check_frame();

    // Reset in the middle of a conversion discards the partial result.
    num_i = BIN_W'(4321); load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    repeat (6) @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_sel", 32'(sel_o), 32'd1);
    check("mid_rst_a2g", 32'(a2g_o), 32'b1111110);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_ovf", 32'(ovf_o), 32'd0);
    shown = 0;
    @(negedge clk);
    rst_ni = 1'b1;
    check_frame();
    $display("mid-conversion reset: display back to 0");

    do_load(7, -1); check_frame();

    for (int i = 0; i < 10; i++) begin
      int v;
      v = (i % 4 == 3) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
      do_load(v, -1);
      check_frame();
    end

    // load_i held high: back-to-back conversions, one every BIN_W+2 cycles.
    num_i = BIN_W'(321); load_i = 1'b1;
    period = 0;
    while (!busy_o && period < 40) begin @(negedge clk); period++; end
    period = 0;
    while (busy_o && period < 40) begin @(negedge clk); period++; end
    while (!busy_o && period < 80) begin @(negedge clk); period++; end
    check("held_period", 32'(period), 32'(BIN_W + 2));
    $display("held load: period %0d cycles", period);
    load_i = 1'b0;
    period = 0;
    while (busy_o && period < 40) begin @(negedge clk); period++; end
    shown = 321;
    check_frame();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
